// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that grants one requester at a time to a
// shared UART transmitter. Each grant latches the byte, pulses ack/tx_start,
// and then holds off further grants for one full frame plus an idle gap.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int BIT_CYCLES = 1,
  parameter int FRAME_BITS = 11,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               busy,
  output logic [2:0]         grant_id,
  output logic               frame_done
);

  localparam int F      = FRAME_BITS * BIT_CYCLES;
  localparam int G      = GAP_CYCLES;
  localparam int MAXC   = (F > G) ? F : G;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int PW     = $clog2(N_REQ);
  localparam int F_LOAD = F - 1;
  localparam int G_LOAD = (G > 0) ? G - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [2:0]        grant_q, grant_d;
  logic [N_REQ-1:0]  ack_q, ack_d;
  logic              start_q, start_d;

  logic [7:0]        req_byte [N_REQ];
  logic              sel_found;
  logic [PW-1:0]     sel_idx;

  // Unpack the flat request-data bus into one byte per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_byte[gi] = req_data[8*gi +: 8];
  end

  // Rotating-priority search: first asserted request starting at ptr, wrapping.
  always_comb begin
    int cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_q) + k) % N_REQ;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PW-1:0];
      end
    end
  end

  // State register and all datapath registers; reset abandons any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      tx_data_q <= 8'h00;
      grant_q   <= 3'd0;
      ack_q     <= '0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      start_q   <= start_d;
    end
  end

  // Next-state logic: grant only from IDLE, then count out frame and gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    grant_d   = grant_q;
    ack_d     = '0;
    start_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          state_d         = S_SEND;
          cnt_d           = CW'(F_LOAD);
          ptr_d           = (sel_idx == PW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
          tx_data_d       = req_byte[sel_idx];
          grant_d         = 3'(sel_idx);
          ack_d[sel_idx]  = 1'b1;
          start_d         = 1'b1;
        end
      end
      S_SEND: begin
        if (cnt_q == '0) begin
          if (G > 0) begin
            state_d = S_GAP;
            cnt_d   = CW'(G_LOAD);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pulses and byte come from registers; busy/frame_done decode state.
  always_comb begin
    ack        = ack_q;
    tx_start   = start_q;
    tx_data    = tx_data_q;
    grant_id   = grant_q;
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_SEND) && (cnt_q == '0);
  end

endmodule
